// File: rtl/dab_gate_driver_pkg.sv
// dab_pkg: shared leg state encoding, voltage command codes and gate bit indices
// for the DAB gate driver.
`default_nettype none

package dab_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DT    = 2'd1,
    HI_ON = 2'd2,
    LO_ON = 2'd3
  } leg_state_t;

  localparam logic [1:0] V_POS  = 2'b01;
  localparam logic [1:0] V_ZERO = 2'b00;
  localparam logic [1:0] V_NEG  = 2'b11;
  localparam logic [1:0] V_ILL  = 2'b10;

  localparam int GATE_A_HI = 0;
  localparam int GATE_A_LO = 1;
  localparam int GATE_B_HI = 2;
  localparam int GATE_B_LO = 3;

endpackage

`default_nettype wire

// File: rtl/dab_gate_driver_if.sv
// dab_gate_driver_if: command/gate bundle between modulator (master) and gate driver (slave).
// fault/trip exist only when DAB_GATE_FAULT_EN is defined.
`default_nettype none

interface dab_gate_driver_if;
  logic       en;
  logic [1:0] V1;
  logic [1:0] V2;
  logic [3:0] Sp;
  logic [3:0] Ss;
  logic       cmd_err;
`ifdef DAB_GATE_FAULT_EN
  logic       fault;
  logic       trip;

  modport master (output en, V1, V2, fault, input Sp, Ss, cmd_err, trip);
  modport slave  (input en, V1, V2, fault, output Sp, Ss, cmd_err, trip);
`else
  modport master (output en, V1, V2, input Sp, Ss, cmd_err);
  modport slave  (input en, V1, V2, output Sp, Ss, cmd_err);
`endif
endinterface

`default_nettype wire

// File: rtl/dab_leg_deadtime.sv
// dab_leg_deadtime: one half-bridge leg with registered dead-time interlock.
// Rev 1.0
`default_nettype none

module dab_leg_deadtime
  import dab_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int DT_W     = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic target_hi,
  output logic      upper,
  output logic      lower
);

  localparam logic [DT_W-1:0] c_dt_load = DT_W'(DEADTIME - 1);

  leg_state_t      r_state;
  logic [DT_W-1:0] r_cnt;
  logic            r_upper;
  logic            r_lower;

  // Gates are updated on the same edge as the state so the outgoing switch
  // drops on the edge that enters DT.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_upper <= 1'b0;
      r_lower <= 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          r_state <= DT;
          r_cnt   <= c_dt_load;
          r_upper <= 1'b0;
          r_lower <= 1'b0;
        end
        DT: begin
          if (r_cnt == '0) begin
            r_state <= target_hi ? HI_ON : LO_ON;
            r_upper <= target_hi;
            r_lower <= !target_hi;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HI_ON: begin
          if (!target_hi) begin
            r_state <= DT;
            r_cnt   <= c_dt_load;
            r_upper <= 1'b0;
          end
        end
        LO_ON: begin
          if (target_hi) begin
            r_state <= DT;
            r_cnt   <= c_dt_load;
            r_lower <= 1'b0;
          end
        end
        default: begin
          r_state <= OFF;
          r_upper <= 1'b0;
          r_lower <= 1'b0;
        end
      endcase
    end
  end

  assign upper = r_upper;
  assign lower = r_lower;

endmodule

`default_nettype wire

// File: rtl/dab_gate_driver.sv
// dab_gate_driver: registers V1/V2, decodes leg targets and drives four dead-time legs.
// Optional trip latch enabled by DAB_GATE_FAULT_EN. Rev 1.0
`default_nettype none

module dab_gate_driver
  import dab_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int DT_W     = 8
) (
  input wire logic          clk,
  input wire logic          rst,
  dab_gate_driver_if.slave  bus
);

  logic [1:0] r_v1;
  logic [1:0] r_v2;
  logic       r_cmd_err;
  logic       w_leg_en;
  logic [3:0] w_target_hi;
  logic [3:0] w_upper;
  logic [3:0] w_lower;
  logic [3:0] w_sp;
  logic [3:0] w_ss;

  // The illegal code is stored as zero so the bridges freewheel on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= V_ZERO;
      r_v2      <= V_ZERO;
      r_cmd_err <= 1'b0;
    end else begin
      r_v1      <= (bus.V1 == V_ILL) ? V_ZERO : bus.V1;
      r_v2      <= (bus.V2 == V_ILL) ? V_ZERO : bus.V2;
      r_cmd_err <= (bus.V1 == V_ILL) || (bus.V2 == V_ILL);
    end
  end

`ifdef DAB_GATE_FAULT_EN
  logic r_trip;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trip <= 1'b0;
    end else if (bus.fault) begin
      r_trip <= 1'b1;
    end
  end

  assign w_leg_en = bus.en && !r_trip && !bus.fault;
  assign bus.trip = r_trip;
`else
  assign w_leg_en = bus.en;
`endif

  // Leg order: primary A, primary B, secondary A, secondary B.
  assign w_target_hi[0] = (r_v1 == V_POS);
  assign w_target_hi[1] = (r_v1 == V_NEG);
  assign w_target_hi[2] = (r_v2 == V_POS);
  assign w_target_hi[3] = (r_v2 == V_NEG);

  for (genvar i = 0; i < 4; i++) begin : g_leg
    dab_leg_deadtime #(
      .DEADTIME (DEADTIME),
      .DT_W     (DT_W)
    ) u_leg (
      .clk       (clk),
      .rst       (rst),
      .en        (w_leg_en),
      .target_hi (w_target_hi[i]),
      .upper     (w_upper[i]),
      .lower     (w_lower[i])
    );
  end

  always_comb begin
    w_sp            = '0;
    w_ss            = '0;
    w_sp[GATE_A_HI] = w_upper[0];
    w_sp[GATE_A_LO] = w_lower[0];
    w_sp[GATE_B_HI] = w_upper[1];
    w_sp[GATE_B_LO] = w_lower[1];
    w_ss[GATE_A_HI] = w_upper[2];
    w_ss[GATE_A_LO] = w_lower[2];
    w_ss[GATE_B_HI] = w_upper[3];
    w_ss[GATE_B_LO] = w_lower[3];
  end

  assign bus.Sp      = w_sp;
  assign bus.Ss      = w_ss;
  assign bus.cmd_err = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_dab_gate_driver.sv
// tb_dab_gate_driver: directed and randomized stimulus against a cycle-timeline reference model.
`default_nettype none

module tb_dab_gate_driver;

  localparam int DEADTIME = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dab_gate_driver_if bus();

  dab_gate_driver #(.DEADTIME(DEADTIME), .DT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each leg is "idle" (disabled), or has a conducting
  // switch (1=upper, 2=lower, 0=none) plus the absolute edge at which the
  // pending dead band ends.
  int         edge_n = 0;
  int         on_sw[4];
  bit         idle[4];
  int         ready_at[4];
  logic [1:0] m_v1, m_v2;
  bit         m_cmd_err, m_trip;

  function automatic int code_val(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic bit fault_now();
`ifdef DAB_GATE_FAULT_EN
    return bus.fault;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit en_eff;
    edge_n++;
    en_eff = bus.en && !m_trip && !fault_now();
    for (int i = 0; i < 4; i++) begin
      int v    = (i < 2) ? code_val(m_v1) : code_val(m_v2);
      int want = (((i % 2) == 0) ? (v > 0) : (v < 0)) ? 1 : 2;
      if (rst || !en_eff) begin
        on_sw[i] = 0;
        idle[i]  = 1;
      end else if (idle[i]) begin
        idle[i]     = 0;
        ready_at[i] = edge_n + DEADTIME;
      end else if (on_sw[i] != 0) begin
        if (on_sw[i] != want) begin
          on_sw[i]    = 0;
          ready_at[i] = edge_n + DEADTIME;
        end
      end else if (edge_n == ready_at[i]) begin
        on_sw[i] = want;
      end
    end
    if (rst) begin
      m_v1 = 2'b00; m_v2 = 2'b00; m_cmd_err = 0; m_trip = 0;
    end else begin
      m_cmd_err = (bus.V1 == 2'b10) || (bus.V2 == 2'b10);
      m_v1      = (bus.V1 == 2'b10) ? 2'b00 : bus.V1;
      m_v2      = (bus.V2 == 2'b10) ? 2'b00 : bus.V2;
      m_trip    = m_trip || fault_now();
    end
  endtask

  function automatic logic [3:0] exp_gates(input int a, input int b);
    return {on_sw[b] == 2, on_sw[b] == 1, on_sw[a] == 2, on_sw[a] == 1};
  endfunction

  bit band_mon = 0;
  int zero_run = 0;
  int cmd_pulses = 0;

  task automatic compare();
    check("Sp", 32'(bus.Sp), 32'(exp_gates(0, 1)));
    check("Ss", 32'(bus.Ss), 32'(exp_gates(2, 3)));
    check("cmd_err", 32'(bus.cmd_err), 32'(m_cmd_err));
    check("interlock",
          32'((bus.Sp[0] & bus.Sp[1]) | (bus.Sp[2] & bus.Sp[3]) |
              (bus.Ss[0] & bus.Ss[1]) | (bus.Ss[2] & bus.Ss[3])), 32'd0);
`ifdef DAB_GATE_FAULT_EN
    check("trip", 32'(bus.trip), 32'(m_trip));
`endif
    if (bus.cmd_err) cmd_pulses++;
    if (band_mon) begin
      if (bus.Sp[1:0] == 2'b00) begin
        zero_run++;
      end else begin
        if (zero_run > 0) check("deadband_len", 32'(zero_run), 32'(DEADTIME));
        zero_run = 0;
      end
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare();
    end
  endtask

  function automatic logic [1:0] rand_code();
    int r = int'($urandom_range(0, 15));
    if (r == 0) return 2'b10;
    case (r % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  initial begin
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.V1 = 2'b00;
    bus.V2 = 2'b00;
`ifdef DAB_GATE_FAULT_EN
    bus.fault = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      on_sw[i] = 0; idle[i] = 1; ready_at[i] = 0;
    end
    m_v1 = 0; m_v2 = 0; m_cmd_err = 0; m_trip = 0;

    tick(3);
    check("reset_Sp", 32'(bus.Sp), 32'h0);
    check("reset_Ss", 32'(bus.Ss), 32'h0);

    // Release: DT entry on first edge, lower switches after DEADTIME.
    rst = 1'b0;
    tick(DEADTIME);
    check("pre_release_Sp", 32'(bus.Sp), 32'h0);
    tick(4);
    check("release_Sp", 32'(bus.Sp), 32'hA);
    check("release_Ss", 32'(bus.Ss), 32'hA);

    bus.V1 = 2'b01;
    tick(DEADTIME + 4);
    check("pos_Sp", 32'(bus.Sp), 32'h9);

    // Fast toggling: every dead band on leg A must still be DEADTIME long.
    band_mon = 1;
    zero_run = 0;
    for (int t = 0; t < 12; t++) begin
      bus.V1 = (t % 2 == 0) ? 2'b11 : 2'b01;
      tick(3);
    end
    bus.V1 = 2'b11;
    tick(DEADTIME + 4);
    band_mon = 0;
    check("neg_Sp", 32'(bus.Sp), 32'h6);

    // One-cycle illegal code on V2.
    bus.V2 = 2'b01;
    tick(DEADTIME + 4);
    cmd_pulses = 0;
    bus.V2 = 2'b10;
    tick(1);
    bus.V2 = 2'b00;
    tick(DEADTIME + 4);
    check("cmd_err_pulses", 32'(cmd_pulses), 32'd1);
    check("ill_Ss", 32'(bus.Ss), 32'hA);

    // en dropped mid-DT, then re-raised.
    bus.V1 = 2'b01;
    tick(4);
    bus.en = 1'b0;
    tick(1);
    check("en_off_Sp", 32'(bus.Sp), 32'h0);
    tick(2);
    bus.en = 1'b1;
    tick(DEADTIME + 3);
    check("reenable_Sp", 32'(bus.Sp), 32'h9);

`ifdef DAB_GATE_FAULT_EN
    bus.fault = 1'b1;
    tick(1);
    bus.fault = 1'b0;
    check("fault_trip", 32'(bus.trip), 32'd1);
    tick(1);
    check("fault_Sp", 32'(bus.Sp), 32'h0);
    bus.en = 1'b0; tick(2); bus.en = 1'b1;
    tick(DEADTIME + 4);
    check("fault_hold_Sp", 32'(bus.Sp), 32'h0);
    check("fault_hold_trip", 32'(bus.trip), 32'd1);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(DEADTIME + 2);
`endif

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) bus.V1 = rand_code();
      else if (bus.V1 == 2'b10) bus.V1 = 2'b00;
      if ($urandom_range(0, 4) == 0) bus.V2 = rand_code();
      else if (bus.V2 == 2'b10) bus.V2 = 2'b00;
      bus.en = ($urandom_range(0, 39) != 0);
      rst    = ($urandom_range(0, 249) == 0);
`ifdef DAB_GATE_FAULT_EN
      bus.fault = ($urandom_range(0, 399) == 0);
`endif
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
